// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
// mult_div_pkg : shared constants and state encoding for the HI/LO sequencer
// Revision     : 1.0
// ============================================================================
package mult_div_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_FIX  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mult_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// mult_div_ctrl_if : request/result bundle between control FSM and mul/div unit
// Revision         : 1.0
// ============================================================================
interface mult_div_ctrl_if #(
  parameter int WIDTH = mult_div_pkg::WIDTH_DEF
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             hilo_write;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hilo_write, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hilo_write, div0, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/mult_div_negate.sv
`default_nettype none
// ============================================================================
// mult_div_negate : conditional two's-complement negation
// Revision        : 1.0
// ============================================================================
module mult_div_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (-din) : din;

endmodule
`default_nettype wire

// File: rtl/mult_div_ctrl.sv
`default_nettype none
// ============================================================================
// mult_div_ctrl : 32-iteration signed shift-add multiply / restoring divide
// Revision      : 1.0
// ============================================================================
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic          clock,
  input  logic          reset,
  mult_div_ctrl_if.slave bus
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_q, op_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div0_q, div0_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh;
  logic                 div_ok;
  logic [WIDTH-1:0]     rem_sub;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign a_mag = bus.a[WIDTH-1] ? (-bus.a) : bus.a;
  assign b_mag = bus.b[WIDTH-1] ? (-bus.b) : bus.b;

  // Multiply: acc = {partial product, remaining multiplier}; carry kept in mul_sum[WIDTH].
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide: acc = {remainder, quotient}; shifted remainder needs one extra bit.
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ok   = (rem_sh >= {1'b0, mag_q});
  assign rem_sub  = rem_sh[WIDTH-1:0] - mag_q;
  assign div_next = div_ok ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  mult_div_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
    .neg  (sa_q ^ sb_q),
    .din  (acc_q),
    .dout (prod_fix)
  );

  mult_div_negate #(.WIDTH(WIDTH)) u_neg_quo (
    .neg  (sa_q ^ sb_q),
    .din  (acc_q[WIDTH-1:0]),
    .dout (quo_fix)
  );

  mult_div_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .neg  (sa_q),
    .din  (acc_q[2*WIDTH-1:WIDTH]),
    .dout (rem_fix)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_DIV && bus.b == '0) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_CALC;
            op_d    = bus.op;
            sa_d    = bus.a[WIDTH-1];
            sb_d    = bus.b[WIDTH-1];
            cnt_d   = '0;
            // mag holds the multiplicand (MULT) or the divisor (DIV).
            if (bus.op == OP_MULT) begin
              mag_d = a_mag;
              acc_d = {{WIDTH{1'b0}}, b_mag};
            end else begin
              mag_d = b_mag;
              acc_d = {{WIDTH{1'b0}}, a_mag};
            end
          end
        end
      end
      ST_CALC: begin
        acc_d = (op_q == OP_MULT) ? mul_next : div_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (op_q == OP_MULT) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    div0_d = (state_d == ST_ERR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      mag_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.hilo_write = done_q;
  assign bus.div0       = div0_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mult_div_ctrl : vector table plus scoreboard for the mul/div sequencer
// Revision         : 1.0
// ============================================================================
module tb_mult_div_ctrl;
  import mult_div_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[11];
  int   lat;

  mult_div_ctrl_if #(.WIDTH(W)) bus ();

  mult_div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done/div0 pulse must match the oldest expected result.
  always @(negedge clock) begin
    if (!reset && (bus.done || bus.div0)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: done=%0b div0=%0b with no expected result", bus.done, bus.div0);
      end else begin
        e = sb.pop_front();
        chk("sb_done", {63'd0, bus.done}, {63'd0, !e.div0});
        chk("sb_div0", {63'd0, bus.div0}, {63'd0, e.div0});
        chk("sb_hilo_write", {63'd0, bus.hilo_write}, {63'd0, !e.div0});
        chk("sb_hi", {32'd0, bus.hi}, {32'd0, e.hi});
        chk("sb_lo", {32'd0, bus.lo}, {32'd0, e.lo});
      end
    end
  end

  // Entered just after a negedge with the DUT idle; that cycle is cycle 0.
  task automatic run_vec(input vec_t v, input string tag);
    int   l = 0;
    logic busy_ok = 1'b1;
    sb.push_back('{div0: v.div0, hi: v.hi, lo: v.lo});
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.a     = v.a;
    bus.b     = v.b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done || bus.div0) begin
        l = k;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(l), v.div0 ? 64'd1 : 64'd34);
    chk({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
    @(negedge clock);
    chk({tag, "_idle"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0]  = '{OP_MULT, 32'h00000007, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{OP_MULT, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
    vecs[2]  = '{OP_MULT, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'h00000000, 32'hFFFE0001};
    vecs[3]  = '{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001};
    vecs[4]  = '{OP_MULT, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000};
    vecs[5]  = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[6]  = '{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000};
    vecs[8]  = '{OP_DIV,  32'h00000003, 32'h00000007, 1'b0, 32'h00000003, 32'h00000000};
    vecs[9]  = '{OP_DIV,  32'h00000692, 32'h00000020, 1'b0, 32'h00000012, 32'h00000034};
    vecs[10] = '{OP_DIV,  32'h00000005, 32'h00000000, 1'b1, 32'h00000012, 32'h00000034};

    @(negedge clock);
    @(negedge clock);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_hilo_write", {63'd0, bus.hilo_write}, 64'd0);
    chk("rst_div0", {63'd0, bus.div0}, 64'd0);
    chk("rst_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Restart requests during a busy MULT must be ignored.
    sb.push_back('{div0: 1'b0, hi: 32'd0, lo: 32'd12});
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    lat       = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 5 || k == 20) begin
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd9;
        bus.b     = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done || bus.div0) begin
        lat = k;
        break;
      end
    end
    chk("noise_latency", 64'(lat), 64'd34);
    @(negedge clock);
    run_vec('{OP_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0, 32'hFFFFFFFE, 32'h0000000E}, "restart35");

    // Reset in cycle 10 of a DIV aborts it and clears HI/LO.
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_div0", {63'd0, bus.div0}, 64'd0);
    chk("abort_hi", {32'd0, bus.hi}, 64'd0);
    chk("abort_lo", {32'd0, bus.lo}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    run_vec('{OP_DIV, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14}, "post_reset");

    repeat (3) @(negedge clock);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
